// File: rtl/hc148_key_debounce.sv
// Eight-channel synchroniser and debouncer feeding the HC148 priority encoder.
// Produces clean active-low levels plus one-cycle press/release pulses.
module hc148_key_debounce #(
   parameter int TICK_DIV     = 50000,
   parameter int STABLE_TICKS = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] KeyIn,
   output logic [7:0] DataOut,
   output logic [7:0] Press,
   output logic [7:0] Release,
   output logic       AnyDown
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(STABLE_TICKS);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

   logic [7:0]    s1;
   logic [7:0]    s2;
   logic [PW-1:0] pre;
   logic          tick;
   logic [CW-1:0] cnt     [8];
   logic [CW-1:0] cnt_nxt [8];
   logic [7:0]    out_nxt;
   logic [7:0]    press_nxt;
   logic [7:0]    rel_nxt;

   assign tick    = (pre == PMAX);
   assign AnyDown = ~&DataOut;

   // Agreement always wins, even on a tick, so a revert clears pending counts.
   always_comb begin
      cnt_nxt   = cnt;
      out_nxt   = DataOut;
      press_nxt = '0;
      rel_nxt   = '0;
      for (int i = 0; i < 8; i++) begin
         if (s2[i] == DataOut[i]) begin
            cnt_nxt[i] = '0;
         end else if (tick && cnt[i] == CMAX) begin
            out_nxt[i]   = s2[i];
            cnt_nxt[i]   = '0;
            press_nxt[i] = ~s2[i];
            rel_nxt[i]   = s2[i];
         end else if (tick) begin
            cnt_nxt[i] = cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1      <= 8'hFF;
         s2      <= 8'hFF;
         pre     <= '0;
         DataOut <= 8'hFF;
         Press   <= '0;
         Release <= '0;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
      end else begin
         s1      <= KeyIn;
         s2      <= s1;
         pre     <= tick ? '0 : pre + PW'(1);
         DataOut <= out_nxt;
         Press   <= press_nxt;
         Release <= rel_nxt;
         for (int i = 0; i < 8; i++) cnt[i] <= cnt_nxt[i];
      end
   end

endmodule

// File: tb/tb_hc148_key_debounce.sv
// Randomised and directed bench for hc148_key_debounce against a
// tick-counting reference model.
module tb_hc148_key_debounce;

   localparam int TD = 4;
   localparam int ST = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] key;
   logic [7:0] dout;
   logic [7:0] press;
   logic [7:0] rel;
   logic       any_down;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   hc148_key_debounce #(.TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .Clk    (clk),
      .Reset  (rst),
      .KeyIn  (key),
      .DataOut(dout),
      .Press  (press),
      .Release(rel),
      .AnyDown(any_down)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference: a line is accepted once it has disagreed with the output
   // across ST sample ticks without interruption.
   logic [7:0] m_s1, m_s2, m_out, m_press, m_rel;
   int         m_run [8];
   int         m_phase;

   always @(posedge clk) begin
      if (rst) begin
         m_s1 = 8'hFF;
         m_s2 = 8'hFF;
         m_out = 8'hFF;
         m_press = '0;
         m_rel = '0;
         m_phase = 0;
         for (int i = 0; i < 8; i++) m_run[i] = 0;
      end else begin
         m_press = '0;
         m_rel = '0;
         for (int i = 0; i < 8; i++) begin
            if (m_s2[i] == m_out[i]) m_run[i] = 0;
            else if (m_phase % TD == TD - 1) begin
               m_run[i]++;
               if (m_run[i] == ST) begin
                  m_out[i] = m_s2[i];
                  m_run[i] = 0;
                  if (m_s2[i]) m_rel[i] = 1'b1;
                  else m_press[i] = 1'b1;
               end
            end
         end
         m_phase++;
         m_s2 = m_s1;
         m_s1 = key;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_dout", dout, m_out);
         chk("m_press", press, m_press);
         chk("m_rel", rel, m_rel);
         chk("m_any", {7'b0, any_down}, {7'b0, ~&m_out});
      end
   end

   function automatic logic [3:0] hc148(input logic [7:0] d);
      logic [3:0] r;
      r = 4'b1111;
      for (int i = 0; i < 8; i++)
         if (!d[i]) r = {~3'(i), 1'b0};
      return r;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n;
      logic [3:0] enc;
      rst = 1'b1;
      key = 8'h00;
      @(negedge clk);
      chk_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_dout", dout, 8'hFF);
         chk("rst_pulse", press | rel, 8'h00);
         chk("rst_any", {7'b0, any_down}, 8'h00);
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_dout", dout, 8'hFF);
      chk("post_rst_any", {7'b0, any_down}, 8'h00);
      key = 8'hFF;
      cyc(20);

      // clean press on channel 5
      key[5] = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dout == 8'hFF && n < 40);
      chk("press_dout", dout, 8'hDF);
      chk("press_lat", {7'b0, n >= 11 && n <= 14}, 8'd1);
      chk("press_pulse", press, 8'h20);
      chk("press_any", {7'b0, any_down}, 8'd1);
      enc = hc148(dout);
      chk("enc_code", {5'b0, enc[3:1]}, 8'h02);
      chk("enc_gs", {7'b0, enc[0]}, 8'h00);
      @(negedge clk);
      chk("press_once", press, 8'h00);
      key[5] = 1'b1;
      cyc(20);

      // bounce on channel 2
      key[2] = 1'b0; cyc(5);
      key[2] = 1'b1; cyc(3);
      key[2] = 1'b0; cyc(5);
      key[2] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         chk("bnc_dout", dout, 8'hFF);
         chk("bnc_pulse", press | rel, 8'h00);
         @(negedge clk);
      end

      // simultaneous channels 0 and 7
      key = 8'h7E;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dout == 8'hFF && n < 40);
      chk("sim_dout", dout, 8'h7E);
      chk("sim_press", press, 8'h81);
      key = 8'hFF;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (dout != 8'hFF && n < 40);
      chk("sim_rel_dout", dout, 8'hFF);
      chk("sim_rel", rel, 8'h81);
      cyc(10);

      // reset in the middle of a count on channel 3
      key[3] = 1'b0;
      n = 0;
      while (m_run[3] < 2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      cyc(2);
      chk("mid_rst_dout", dout, 8'hFF);
      chk("mid_rst_rel", rel, 8'h00);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         chk("mid_no_rel", rel, 8'h00);
      end while (dout[3] && n < 40);
      chk("mid_dout", dout, 8'hF7);
      chk("mid_lat", {7'b0, n >= 11 && n <= 14}, 8'd1);
      key[3] = 1'b1;
      cyc(20);

      // revert on channel 1 exactly in a tick cycle with two ticks counted
      key[1] = 1'b0;
      n = 0;
      while (!(m_run[1] == 2 && m_phase % TD == 1) && n < 60) begin
         @(negedge clk);
         n++;
      end
      key[1] = 1'b1;
      cyc(3);
      chk("col_cnt", {6'b0, dut.cnt[1]}, 8'h00);
      chk("col_dout", dout, 8'hFF);
      cyc(20);

      // random traffic with random hold times
      for (int k = 0; k < 60; k++) begin
         key = key ^ 8'($urandom);
         cyc($urandom_range(1, 20));
      end
      key = 8'hFF;
      cyc(30);
      chk("end_dout", dout, 8'hFF);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
